// File: rtl/rvh_l1d_pkg.sv
// rvh_l1d_pkg: shared widths, defaults and the writeback entry type for the L1D load writeback arbiter.
package rvh_l1d_pkg;
    localparam int ROB_TAG_WIDTH      = 6;
    localparam int PREG_TAG_WIDTH     = 7;
    localparam int XLEN               = 64;
    localparam int DEF_REFILL_Q_DEPTH = 4;
    localparam int DEF_STARVE_LIMIT   = 8;

    typedef struct packed {
        logic [ROB_TAG_WIDTH-1:0]  rob_tag;
        logic [PREG_TAG_WIDTH-1:0] prd;
        logic [XLEN-1:0]           data;
    } ld_wb_entry_t;
endpackage

// File: rtl/rvh_l1d_ld_wb_arb_if.sv
// rvh_l1d_ld_wb_arb_if: hit/refill response inputs and ROB/PRF writeback outputs of the load writeback arbiter.
interface rvh_l1d_ld_wb_arb_if;
    import rvh_l1d_pkg::*;
    logic                      hit_vld_i;
    logic [ROB_TAG_WIDTH-1:0]  hit_rob_tag_i;
    logic [PREG_TAG_WIDTH-1:0] hit_prd_i;
    logic [XLEN-1:0]           hit_data_i;
    logic                      refill_vld_i;
    logic                      refill_rdy_o;
    logic [ROB_TAG_WIDTH-1:0]  refill_rob_tag_i;
    logic [PREG_TAG_WIDTH-1:0] refill_prd_i;
    logic [XLEN-1:0]           refill_data_i;
    logic                      flush_i;
    logic                      ld_issue_stall_o;
    logic                      l1d_rob_wb_vld_o;
    logic [ROB_TAG_WIDTH-1:0]  l1d_rob_wb_rob_tag_o;
    logic                      l1d_int_prf_wb_vld_o;
    logic [PREG_TAG_WIDTH-1:0] l1d_int_prf_wb_tag_o;
    logic [XLEN-1:0]           l1d_int_prf_wb_data_o;
    logic                      l1d_int_prf_wb_vld_from_mlfb_o;

    modport slave (
        input  hit_vld_i, hit_rob_tag_i, hit_prd_i, hit_data_i,
        input  refill_vld_i, refill_rob_tag_i, refill_prd_i, refill_data_i, flush_i,
        output refill_rdy_o, ld_issue_stall_o,
        output l1d_rob_wb_vld_o, l1d_rob_wb_rob_tag_o,
        output l1d_int_prf_wb_vld_o, l1d_int_prf_wb_tag_o, l1d_int_prf_wb_data_o,
        output l1d_int_prf_wb_vld_from_mlfb_o
    );

    modport master (
        output hit_vld_i, hit_rob_tag_i, hit_prd_i, hit_data_i,
        output refill_vld_i, refill_rob_tag_i, refill_prd_i, refill_data_i, flush_i,
        input  refill_rdy_o, ld_issue_stall_o,
        input  l1d_rob_wb_vld_o, l1d_rob_wb_rob_tag_o,
        input  l1d_int_prf_wb_vld_o, l1d_int_prf_wb_tag_o, l1d_int_prf_wb_data_o,
        input  l1d_int_prf_wb_vld_from_mlfb_o
    );
endinterface

// File: rtl/rvh_l1d_ld_wb_fifo.sv
// rvh_l1d_ld_wb_fifo: synchronous FIFO of writeback entries with flush; overflow/underflow requests are ignored.
module rvh_l1d_ld_wb_fifo
    import rvh_l1d_pkg::*;
#(
    parameter int DEPTH = DEF_REFILL_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ld_wb_entry_t             din,
    input  logic                     pop,
    output ld_wb_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ld_wb_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rp];
    assign full   = r_cnt == CW'(DEPTH);
    assign empty  = r_cnt == '0;
    assign count  = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst | flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/rvh_l1d_ld_wb_arb.sv
// rvh_l1d_ld_wb_arb: shares the L1D load writeback port between the unstallable hit path and queued refill responses,
// with a starvation counter that stalls load issue until queued refills drain.
module rvh_l1d_ld_wb_arb
    import rvh_l1d_pkg::*;
#(
    parameter int REFILL_Q_DEPTH = DEF_REFILL_Q_DEPTH,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
    input logic                clk,
    input logic                rst,
    rvh_l1d_ld_wb_arb_if.slave io
);
    localparam int CW = $clog2(REFILL_Q_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    ld_wb_entry_t  w_hit;
    ld_wb_entry_t  w_ref;
    ld_wb_entry_t  w_head;
    ld_wb_entry_t  w_sel;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_acc;
    logic          w_pop;
    logic          w_byp;
    logic          w_push;
    logic          w_sel_vld;
    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic          r_vld;
    logic          r_mlfb;
    ld_wb_entry_t  r_out;

    assign w_hit = '{rob_tag: io.hit_rob_tag_i, prd: io.hit_prd_i, data: io.hit_data_i};
    assign w_ref = '{rob_tag: io.refill_rob_tag_i, prd: io.refill_prd_i, data: io.refill_data_i};

    // A refill arriving while nothing is queued and the hit path is idle skips the FIFO.
    always_comb begin
        w_acc     = io.refill_vld_i & ~w_full & ~io.flush_i;
        w_pop     = ~io.hit_vld_i & ~w_empty;
        w_byp     = ~io.hit_vld_i & w_empty & w_acc;
        w_push    = w_acc & ~w_byp;
        w_sel_vld = io.hit_vld_i | w_pop | w_byp;
        w_sel     = io.hit_vld_i ? w_hit : (w_empty ? w_ref : w_head);
    end

    rvh_l1d_ld_wb_fifo #(.DEPTH(REFILL_Q_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (io.flush_i),
        .push  (w_push),
        .din   (w_ref),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= 1'b0;
            r_mlfb   <= 1'b0;
            r_out    <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_vld    <= w_sel_vld & ~io.flush_i;
            r_mlfb   <= w_sel_vld & ~io.hit_vld_i & ~io.flush_i;
            if (w_sel_vld) r_out <= w_sel;
            // With a non-empty FIFO, no pop means the hit path won this cycle.
            r_starve <= (io.flush_i | (w_count == '0) | w_pop) ? '0 :
                        (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);
            r_stall  <= io.flush_i ? 1'b0 :
                        (r_starve == SW'(STARVE_LIMIT)) ? 1'b1 :
                        w_empty ? 1'b0 : r_stall;
        end
    end

    assign io.refill_rdy_o                   = ~w_full;
    assign io.ld_issue_stall_o               = r_stall;
    assign io.l1d_rob_wb_vld_o               = r_vld;
    assign io.l1d_rob_wb_rob_tag_o           = r_out.rob_tag;
    assign io.l1d_int_prf_wb_vld_o           = r_vld;
    assign io.l1d_int_prf_wb_tag_o           = r_out.prd;
    assign io.l1d_int_prf_wb_data_o          = r_out.data;
    assign io.l1d_int_prf_wb_vld_from_mlfb_o = r_mlfb;
endmodule

// File: tb/tb_rvh_l1d_ld_wb_arb.sv
// tb_rvh_l1d_ld_wb_arb: directed and random stimulus checked against a queue-based model of the arbiter.
module tb_rvh_l1d_ld_wb_arb;
    import rvh_l1d_pkg::*;

    localparam int DEPTH = DEF_REFILL_Q_DEPTH;
    localparam int LIMIT = DEF_STARVE_LIMIT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvh_l1d_ld_wb_arb_if bus();
    rvh_l1d_ld_wb_arb dut (.clk(clk), .rst(rst), .io(bus));

    int checks = 0;
    int errors = 0;

    ld_wb_entry_t q[$];
    int           m_starve;
    bit           m_stall;
    bit           m_acc;
    bit           e_vld;
    bit           e_mlfb;
    ld_wb_entry_t e_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit hv, input int htag, input bit rv, input int rtag, input bit fl);
        bus.hit_vld_i        = hv;
        bus.hit_rob_tag_i    = ROB_TAG_WIDTH'(htag);
        bus.hit_prd_i        = PREG_TAG_WIDTH'($urandom);
        bus.hit_data_i       = {$urandom, $urandom};
        bus.refill_vld_i     = rv;
        bus.refill_rob_tag_i = ROB_TAG_WIDTH'(rtag);
        bus.refill_prd_i     = PREG_TAG_WIDTH'($urandom);
        bus.refill_data_i    = {$urandom, $urandom};
        bus.flush_i          = fl;
    endtask

    // One clock: advance the model from the current inputs, then compare the registered outputs.
    task automatic cyc();
        ld_wb_entry_t h, r;
        bit rdy, ne;
        h = '{rob_tag: bus.hit_rob_tag_i, prd: bus.hit_prd_i, data: bus.hit_data_i};
        r = '{rob_tag: bus.refill_rob_tag_i, prd: bus.refill_prd_i, data: bus.refill_data_i};
        rdy = q.size() < DEPTH;
        m_acc = 1'b0;
        if (!rst) chk("refill_rdy", bus.refill_rdy_o, rdy);
        if (rst || bus.flush_i) begin
            q.delete();
            m_starve = 0;
            m_stall  = 0;
            e_vld    = 0;
            e_mlfb   = 0;
            if (rst) e_out = '0;
        end else begin
            ne = q.size() != 0;
            if (m_starve == LIMIT) m_stall = 1;
            else if (!ne) m_stall = 0;
            m_starve = (bus.hit_vld_i && ne) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            m_acc = bus.refill_vld_i && rdy;
            e_vld = 1;
            e_mlfb = !bus.hit_vld_i;
            if (bus.hit_vld_i) begin
                e_out = h;
                if (m_acc) q.push_back(r);
            end else if (ne) begin
                e_out = q.pop_front();
                if (m_acc) q.push_back(r);
            end else if (m_acc) begin
                e_out = r;
            end else begin
                e_vld = 0;
                e_mlfb = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("rob_wb_vld", bus.l1d_rob_wb_vld_o, e_vld);
        chk("prf_wb_vld", bus.l1d_int_prf_wb_vld_o, e_vld);
        chk("from_mlfb", bus.l1d_int_prf_wb_vld_from_mlfb_o, e_mlfb);
        chk("stall", bus.ld_issue_stall_o, m_stall);
        if (e_vld || rst) begin
            chk("rob_tag", bus.l1d_rob_wb_rob_tag_o, e_out.rob_tag);
            chk("prd", bus.l1d_int_prf_wb_tag_o, e_out.prd);
            chk("data", bus.l1d_int_prf_wb_data_o, e_out.data);
        end
    endtask

    initial begin
        bit hv;
        int tag;
        drv(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_rdy", bus.refill_rdy_o, 1'b1);
        chk("reset_data", bus.l1d_int_prf_wb_data_o, 64'h0);

        // Refill-only bypass
        drv(0, 0, 1, 5, 0);
        bus.refill_prd_i  = 7'd12;
        bus.refill_data_i = 64'hDEAD_BEEF;
        cyc();
        chk("bypass_tag", bus.l1d_rob_wb_rob_tag_o, 64'd5);
        chk("bypass_prd", bus.l1d_int_prf_wb_tag_o, 64'd12);
        chk("bypass_data", bus.l1d_int_prf_wb_data_o, 64'hDEAD_BEEF);
        chk("bypass_mlfb", bus.l1d_int_prf_wb_vld_from_mlfb_o, 1'b1);
        drv(0, 0, 0, 0, 0);
        cyc();
        chk("bypass_fifo_empty", bus.l1d_rob_wb_vld_o, 1'b0);

        // Hit vs refill collision
        drv(1, 3, 1, 7, 0);
        cyc();
        chk("collide_hit_tag", bus.l1d_rob_wb_rob_tag_o, 64'd3);
        chk("collide_hit_mlfb", bus.l1d_int_prf_wb_vld_from_mlfb_o, 1'b0);
        drv(0, 0, 0, 0, 0);
        cyc();
        chk("collide_ref_tag", bus.l1d_rob_wb_rob_tag_o, 64'd7);
        chk("collide_ref_mlfb", bus.l1d_int_prf_wb_vld_from_mlfb_o, 1'b1);
        cyc();

        // Backpressure: continuous hit, five refills offered
        for (int i = 0; i < 5; i++) begin
            drv(1, 20 + i, 1, 40 + i, 0);
            cyc();
        end
        chk("bp_rdy_low", bus.refill_rdy_o, 1'b0);
        drv(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc();
        chk("bp_drained_stall", bus.ld_issue_stall_o, 1'b0);

        // Starvation with one queued entry
        drv(1, 1, 1, 50, 0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drv(1, 2 + i, 0, 0, 0);
            cyc();
        end
        chk("starve_stall_set", bus.ld_issue_stall_o, 1'b1);
        drv(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc();
        chk("starve_stall_clear", bus.ld_issue_stall_o, 1'b0);

        // Flush with three queued entries and a pending hit
        for (int i = 0; i < 3; i++) begin
            drv(1, 10 + i, 1, 30 + i, 0);
            cyc();
        end
        drv(1, 15, 1, 33, 1);
        cyc();
        chk("flush_no_wb", bus.l1d_rob_wb_vld_o, 1'b0);
        chk("flush_rdy", bus.refill_rdy_o, 1'b1);
        drv(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc();

        // Pointer wrap: hold count at 2 with push+pop every cycle
        for (int i = 0; i < 2; i++) begin
            drv(1, 60 + i, 1, i, 0);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            drv(0, 0, 1, 2 + i, 0);
            cyc();
            chk("wrap_order", bus.l1d_rob_wb_rob_tag_o, 64'(i));
        end
        drv(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc();

        // Reset mid-operation with queued entries and a pending writeback
        for (int i = 0; i < 3; i++) begin
            drv(1, 5 + i, 1, 25 + i, 0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0);
        cyc();
        chk("rst_mid_no_stale", bus.l1d_rob_wb_vld_o, 1'b0);

        // Random traffic; the refill source holds its request until accepted
        for (int n = 0; n < 600; n++) begin
            hv  = bus.ld_issue_stall_o ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            tag = $urandom_range(0, 63);
            if (bus.refill_vld_i && !m_acc) begin
                bus.hit_vld_i     = hv;
                bus.hit_rob_tag_i = ROB_TAG_WIDTH'(tag);
                bus.hit_prd_i     = PREG_TAG_WIDTH'($urandom);
                bus.hit_data_i    = {$urandom, $urandom};
                bus.flush_i       = ($urandom_range(0, 49) == 0);
            end else begin
                drv(hv, tag, $urandom_range(0, 2) != 0, $urandom_range(0, 63), $urandom_range(0, 49) == 0);
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
